// File: rtl/ext_pipe.sv
// ext_pipe: load/immediate extension unit feeding a DEPTH-entry result FIFO.
// Defining EXT_MISALIGN_EN adds the oMisalign output, stored alongside each entry.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iFlush,
  input  logic              iValid,
  output logic              oReady,
  input  logic [31:0]       iData,
  input  logic [2:0]        iMode,
  input  logic [1:0]        iOff,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData
`ifdef EXT_MISALIGN_EN
  ,
  output logic              oMisalign
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane, imm;
  logic [DATA_W-1:0] ext;
  logic              enq, deq;

  always_comb begin
    byte_lane = iData[{iOff, 3'b000} +: 8];
    half_lane = iOff[1] ? iData[31:16] : iData[15:0];
    imm       = iData[15:0];
    case (iMode)
      3'd0:    ext = DATA_W'($signed(iData));
      3'd1:    ext = DATA_W'($signed(half_lane));
      3'd2:    ext = DATA_W'(half_lane);
      3'd3:    ext = DATA_W'($signed(byte_lane));
      3'd4:    ext = DATA_W'(byte_lane);
      3'd5:    ext = DATA_W'($signed(imm));
      3'd6:    ext = DATA_W'(imm);
      default: ext = DATA_W'($signed({imm, 16'h0000}));
    endcase
  end

  // oReady includes the pass-through case: a full buffer accepts when the head leaves.
  assign oValid = (count != '0);
  assign deq    = oValid && iReady;
  assign oReady = (count < FULL) || deq;
  assign enq    = iValid && oReady && !iFlush;
  assign oData  = oValid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= ext;
  end

  always_ff @(posedge clk) begin
    if (rst || iFlush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (enq) wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (deq) rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
    end
  end

`ifdef EXT_MISALIGN_EN
  logic mis_mem [DEPTH];
  logic mis_in;

  assign mis_in = ((iMode == 3'd1 || iMode == 3'd2) && iOff[0]) ||
                  (iMode == 3'd0 && iOff != 2'd0);
  assign oMisalign = oValid ? mis_mem[rptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (enq) mis_mem[wptr] <= mis_in;
  end
`endif

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32, output datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, buffer entries; legal values 2 to 8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 iFlush  input  1  synchronous discard of all buffered entries.
REQ-006 iValid  input  1  upstream item present.
REQ-007 oReady  output  1  ext_pipe can accept an item.
REQ-008 iData  input  32  raw load word or instruction word.
REQ-009 iMode  input  3  extension mode, per REQ-014.
REQ-010 iOff  input  2  byte offset within the word, little-endian.
REQ-011 oValid  output  1  result available.
REQ-012 iReady  input  1  downstream accepts result.
REQ-013 oData  output  DATA_W  extended result.

Function
REQ-014 Modes, where imm is iData[15:0] and SE/ZE mean sign-/zero-extend to DATA_W: 000 word SE; 001 half SE; 010 half ZE; 011 byte SE; 100 byte ZE; 101 imm SE; 110 imm ZE; 111 imm placed in bits [31:16], low 16 bits 0, upper bits SE from bit 31.
REQ-015 Byte lane is iData[8*iOff+7 : 8*iOff]; half lane is iData[15:0] when iOff[1]=0, else iData[31:16]; iOff[0] ignored for half modes; iOff ignored for modes 000 and 101-111.
REQ-016 Extension is computed at enqueue; buffer stores DATA_W results only.
REQ-017 Enqueue occurs when iValid and oReady are both high; dequeue occurs when oValid and iReady are both high.
REQ-018 Buffer is FIFO-ordered; the entry count is held in a counter, and read and write pointers wrap modulo DEPTH.
REQ-019 oReady is high iff count < DEPTH, or a dequeue occurs in the same cycle (pass-through when full).
REQ-020 oValid is high iff count > 0; oData is the head entry and is held stable while oValid is high and iReady is low.
REQ-021 Latency is 1 cycle: an item enqueued at edge N is visible on oData after edge N.
REQ-022 Simultaneous enqueue and dequeue leaves count unchanged, including at count = 0 (no bypass) and at count = DEPTH.
REQ-023 iFlush sets count to 0 and resets both pointers; any enqueue in the same cycle is dropped.
REQ-024 Dequeue while count = 0 and enqueue while full without a dequeue are impossible by construction.

Reset
REQ-025 rst sets count = 0, both pointers = 0, oValid = 0, oReady = 1 and oData = 0; rst overrides iFlush and all handshakes.
REQ-026 Reset mid-stream discards all entries; no output is produced from data accepted before rst.

Configuration
REQ-027 Macro EXT_MISALIGN_EN: when defined, the module adds output oMisalign (1 bit, registered with each entry); it is 1 for half modes with iOff[0]=1, and for mode 000 with iOff != 0.
REQ-028 When EXT_MISALIGN_EN is not defined, the oMisalign port and its storage do not exist, and data behaviour is identical.

Verification
REQ-029 Byte SE: iData=32'h1234_80FF, iMode=011, iOff=1, with iReady=1 -> one cycle later oValid=1, oData=32'hFFFF_FF80.
REQ-030 Half ZE/SE: iData=32'h8001_7FFF, iOff=2, iMode=010 -> oData=32'h0000_8001; with iMode=001 -> oData=32'hFFFF_8001; with DATA_W=64 and iMode=001 -> 64'hFFFF_FFFF_FFFF_8001.
REQ-031 Imm modes: iData=32'h0000_F000 -> modes 101, 110 and 111 give 32'hFFFF_F000, 32'h0000_F000 and 32'hF000_0000 respectively.
REQ-032 Backpressure: iReady=0, push DEPTH items -> oReady=0; next cycle, iReady=1 with iValid=1 -> one dequeue and one enqueue, count stays DEPTH, order preserved.
REQ-033 Flush/reset: with 2 items buffered, assert iFlush together with iValid -> next cycle oValid=0, count=0; repeat with rst -> oData=0, oReady=1.
REQ-034 With EXT_MISALIGN_EN defined: iMode=001, iOff=1 -> oMisalign=1; iMode=011, iOff=3 -> oMisalign=0.
